// File: rtl/msx_bus_ctrl_pkg.sv
// Shared constants, wait-FSM state type and mapper reset values for the MSX bus controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package msx_bus_pkg;

    localparam logic [7:0] PORT_PSLOT    = 8'hA8;
    localparam logic [7:0] PORT_MAP_BASE = 8'hFC;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } wait_state_t;

    // Power-on mapping: page 0 -> segment 3, page 1 -> 2, page 2 -> 1, page 3 -> 0.
    function automatic logic [7:0] map_rst_val(input logic [1:0] idx);
        return {6'b0, ~idx};
    endfunction

endpackage

// File: rtl/msx_bus_ctrl_if.sv
// Z80 CPU bus as seen by the MSX bus controller (address, write data, strobes, wait).
// Latency: n/a (wiring only).
// Backpressure: wait_n is the only flow control, driven by the slave back to the CPU.
interface msx_bus_ctrl_if;
    logic [15:0] A;
    logic [7:0]  cpu_dout;
    logic        mreq_n;
    logic        iorq_n;
    logic        rd_n;
    logic        wr_n;
    logic        m1_n;
    logic        rfsh_n;
    logic        wait_n;

    modport master (
        output A, cpu_dout, mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n,
        input  wait_n
    );

    modport slave (
        input  A, cpu_dout, mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n,
        output wait_n
    );
endinterface

// File: rtl/msx_bus_ctrl_m1_wait.sv
// M1 wait-state generator: detects the start of each M1 cycle and pulls wait_n low.
// Latency: wait_n falls one clock after the trigger and stays low for M1_WAITS clocks.
// Backpressure: this block is the backpressure source; an aborted M1 (m1_n high) releases it.
module msx_m1_wait
    import msx_bus_pkg::*;
#(
    parameter int M1_WAITS = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_m1_n,
    input  logic i_mreq_n,
    input  logic i_iorq_n,
    input  logic i_rfsh_n,
    output logic o_wait_n
);

    localparam bit         WAITS_EN = (M1_WAITS > 0);
    localparam logic [1:0] CNT_LOAD = WAITS_EN ? 2'(M1_WAITS - 1) : 2'd0;

    logic        w_m1_term;
    logic        w_trig;
    logic        r_m1_term_d;
    wait_state_t r_state;
    wait_state_t w_state_nxt;
    logic [1:0]  r_cnt;
    logic [1:0]  w_cnt_nxt;
    logic        r_wait_n;
    logic        w_wait_n_nxt;

    // Fetch or interrupt-ack access outside refresh; its rising edge marks a new M1 cycle.
    assign w_m1_term = ~i_m1_n & (~i_mreq_n | ~i_iorq_n) & i_rfsh_n;
    assign w_trig    = w_m1_term & ~r_m1_term_d;

    // History of the M1 term; reset high so a term already active at reset release is not a new cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_m1_term_d <= 1'b1;
        else          r_m1_term_d <= w_m1_term;
    end

    // State, counter and registered wait output.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 2'd0;
            r_wait_n <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_wait_n <= w_wait_n_nxt;
        end
    end

    // Next state: wait_n_nxt is what the CPU sees after the coming edge.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_wait_n_nxt = 1'b1;
        case (r_state)
            ST_IDLE: begin
                if (w_trig && WAITS_EN) begin
                    w_state_nxt  = ST_WAIT;
                    w_cnt_nxt    = CNT_LOAD;
                    w_wait_n_nxt = 1'b0;
                end
            end
            ST_WAIT: begin
                if (i_m1_n) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == 2'd0) begin
                    w_state_nxt = ST_HOLD;
                end else begin
                    w_cnt_nxt    = r_cnt - 2'd1;
                    w_wait_n_nxt = 1'b0;
                end
            end
            ST_HOLD: begin
                if (i_m1_n) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign o_wait_n = r_wait_n;

endmodule

// File: rtl/msx_bus_ctrl.sv
// MSX bus controller: M1 waits, primary-slot register (A8h), memory mapper (FCh-FFh), memory decode.
// Latency: register writes commit on the clock that samples the write edge; reads and decode are combinational.
// Backpressure: only M1 cycles are stretched via wait_n. Optional macro: MAPPER_READBACK_EN.
module msx_bus_ctrl
    import msx_bus_pkg::*;
#(
    parameter int M1_WAITS = 1,
    parameter int SEG_BITS = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    msx_bus_ctrl_if.slave         bus,
    output logic [1:0]            pslot,
    output logic [SEG_BITS+13:0]  maddr,
    output logic [7:0]            slot_reg,
    output logic [7:0]            io_rdata,
    output logic                  io_rd_hit
);

    logic [7:0]          w_port;
    logic                w_is_pslot;
    logic                w_is_map;
    logic                w_own;
    logic                w_io_wr_n;
    logic                w_wr_fire;
    logic                w_io_rd;
    logic                r_io_wr_n_d;
    logic [7:0]          r_slot;
    logic [SEG_BITS-1:0] r_map [4];
    logic                w_wait_n;

    assign w_port     = bus.A[7:0];
    assign w_is_pslot = (w_port == PORT_PSLOT);
    assign w_is_map   = (w_port[7:2] == PORT_MAP_BASE[7:2]);

    // m1_n gating keeps interrupt acknowledge out of the I/O read/write paths.
    assign w_io_wr_n = ~(~bus.iorq_n & ~bus.wr_n & bus.m1_n);
    assign w_io_rd   = ~bus.iorq_n & ~bus.rd_n & bus.m1_n;
    assign w_wr_fire = r_io_wr_n_d & ~w_io_wr_n;

    // Write-strobe history; one commit per falling edge regardless of strobe length.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_io_wr_n_d <= 1'b1;
        else          r_io_wr_n_d <= w_io_wr_n;
    end

    // Slot and mapper registers, written once per I/O write bus cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_slot <= 8'h00;
            for (int i = 0; i < 4; i++) r_map[i] <= SEG_BITS'(map_rst_val(2'(i)));
        end else if (w_wr_fire) begin
            if (w_is_pslot)    r_slot <= bus.cpu_dout;
            else if (w_is_map) r_map[w_port[1:0]] <= bus.cpu_dout[SEG_BITS-1:0];
        end
    end

`ifdef MAPPER_READBACK_EN
    assign w_own = w_is_pslot | w_is_map;

    // Read mux; unimplemented mapper bits read back as ones.
    always_comb begin
        io_rdata = 8'hFF;
        if (w_io_rd && w_is_pslot) io_rdata = r_slot;
        else if (w_io_rd && w_is_map) io_rdata[SEG_BITS-1:0] = r_map[w_port[1:0]];
    end
`else
    assign w_own = w_is_pslot;

    // Read mux; only the slot register is visible.
    always_comb begin
        io_rdata = 8'hFF;
        if (w_io_rd && w_is_pslot) io_rdata = r_slot;
    end
`endif

    assign io_rd_hit = w_io_rd & w_own;

    // Primary slot for the 16K page addressed by A[15:14].
    always_comb begin
        pslot = r_slot[1:0];
        case (bus.A[15:14])
            2'd0: pslot = r_slot[1:0];
            2'd1: pslot = r_slot[3:2];
            2'd2: pslot = r_slot[5:4];
            2'd3: pslot = r_slot[7:6];
            default: pslot = r_slot[1:0];
        endcase
    end

    assign maddr    = {r_map[bus.A[15:14]], bus.A[13:0]};
    assign slot_reg = r_slot;

    msx_m1_wait #(
        .M1_WAITS (M1_WAITS)
    ) u_m1_wait (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_m1_n   (bus.m1_n),
        .i_mreq_n (bus.mreq_n),
        .i_iorq_n (bus.iorq_n),
        .i_rfsh_n (bus.rfsh_n),
        .o_wait_n (w_wait_n)
    );

    assign bus.wait_n = w_wait_n;

endmodule

// File: tb/tb_msx_bus_ctrl.sv
// Bench for msx_bus_ctrl: two instances (1 wait / 8-bit segments, 2 waits / 2-bit segments) on one bus.
// Directed bus cycles plus random I/O and decode traffic against a register-level model.
// Mapper readback expectations follow MAPPER_READBACK_EN.
module tb_msx_bus_ctrl;

`ifdef MAPPER_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    msx_bus_ctrl_if bus0 ();
    msx_bus_ctrl_if bus1 ();

    assign bus1.A        = bus0.A;
    assign bus1.cpu_dout = bus0.cpu_dout;
    assign bus1.mreq_n   = bus0.mreq_n;
    assign bus1.iorq_n   = bus0.iorq_n;
    assign bus1.rd_n     = bus0.rd_n;
    assign bus1.wr_n     = bus0.wr_n;
    assign bus1.m1_n     = bus0.m1_n;
    assign bus1.rfsh_n   = bus0.rfsh_n;

    logic [1:0]  pslot0, pslot1;
    logic [21:0] maddr0;
    logic [15:0] maddr1;
    logic [7:0]  slot0, slot1, rdat0, rdat1;
    logic        hit0, hit1;

    msx_bus_ctrl #(.M1_WAITS(1), .SEG_BITS(8)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .bus(bus0.slave), .pslot(pslot0), .maddr(maddr0),
        .slot_reg(slot0), .io_rdata(rdat0), .io_rd_hit(hit0)
    );

    msx_bus_ctrl #(.M1_WAITS(2), .SEG_BITS(2)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1.slave), .pslot(pslot1), .maddr(maddr1),
        .slot_reg(slot1), .io_rdata(rdat1), .io_rd_hit(hit1)
    );

    int checks = 0;
    int errors = 0;

    // Reference state
    logic [7:0] m_slot;
    logic [7:0] m_map0 [4];
    logic [1:0] m_map1 [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_slot = 8'h00;
        for (int i = 0; i < 4; i++) begin
            m_map0[i] = 8'(3 - i);
            m_map1[i] = 2'(3 - i);
        end
    endtask

    task automatic model_write(input logic [7:0] port, input logic [7:0] d);
        if (port == 8'hA8) m_slot = d;
        else if (port >= 8'hFC) begin
            m_map0[port[1:0]] = d;
            m_map1[port[1:0]] = d[1:0];
        end
    endtask

    // {hit, data} expected for an IN from port on instance dut
    function automatic logic [8:0] model_rd(input logic [7:0] port, input int dut);
        logic [7:0] mv;
        if (port == 8'hA8) return {1'b1, m_slot};
        if (RB && port >= 8'hFC) begin
            mv = (dut == 0) ? m_map0[port[1:0]] : {6'h3F, m_map1[port[1:0]]};
            return {1'b1, mv};
        end
        return {1'b0, 8'hFF};
    endfunction

    task automatic idle_bus();
        bus0.mreq_n = 1'b1; bus0.iorq_n = 1'b1; bus0.rd_n = 1'b1;
        bus0.wr_n = 1'b1;   bus0.m1_n = 1'b1;   bus0.rfsh_n = 1'b1;
    endtask

    task automatic io_write(input logic [7:0] port, input logic [7:0] d);
        @(posedge clk); #1;
        bus0.A = {8'h00, port}; bus0.cpu_dout = d;
        bus0.iorq_n = 1'b0; bus0.wr_n = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        idle_bus();
        model_write(port, d);
    endtask

    task automatic chk_io(input logic [7:0] port);
        logic [8:0] e0, e1;
        @(posedge clk); #1;
        bus0.A = {8'h00, port}; bus0.iorq_n = 1'b0; bus0.rd_n = 1'b0;
        e0 = model_rd(port, 0);
        e1 = model_rd(port, 1);
        @(negedge clk);
        chk($sformatf("rd_hit0[%h]", port), {31'd0, hit0}, {31'd0, e0[8]});
        chk($sformatf("rd_dat0[%h]", port), {24'd0, rdat0}, {24'd0, e0[7:0]});
        chk($sformatf("rd_hit1[%h]", port), {31'd0, hit1}, {31'd0, e1[8]});
        chk($sformatf("rd_dat1[%h]", port), {24'd0, rdat1}, {24'd0, e1[7:0]});
        @(posedge clk); #1;
        idle_bus();
    endtask

    task automatic chk_map(input logic [15:0] addr);
        int a;
        a = addr;
        @(posedge clk); #1;
        bus0.A = addr;
        @(negedge clk);
        chk($sformatf("pslot0[%h]", addr), {30'd0, pslot0}, (m_slot >> (2 * (a / 16384))) % 4);
        chk($sformatf("pslot1[%h]", addr), {30'd0, pslot1}, (m_slot >> (2 * (a / 16384))) % 4);
        chk($sformatf("maddr0[%h]", addr), {10'd0, maddr0}, m_map0[a / 16384] * 16384 + a % 16384);
        chk($sformatf("maddr1[%h]", addr), {16'd0, maddr1}, m_map1[a / 16384] * 16384 + a % 16384);
    endtask

    // M1 cycle (fetch when iack=0, interrupt ack when iack=1), then a refresh slot.
    task automatic m1_cycle(input string tag, input logic [15:0] addr, input bit iack);
        int lows0, lows1, first0, first1, rf_lows;
        lows0 = 0; lows1 = 0; rf_lows = 0;
        @(posedge clk); #1;
        bus0.A = addr; bus0.m1_n = 1'b0; bus0.cpu_dout = 8'h5A;
        if (iack) begin
            bus0.iorq_n = 1'b0; bus0.rd_n = 1'b0; bus0.wr_n = 1'b0;
        end else begin
            bus0.mreq_n = 1'b0; bus0.rd_n = 1'b0;
        end
        @(negedge clk);
        chk({tag, "_pre_wait0"}, {31'd0, bus0.wait_n}, 32'd1);
        chk({tag, "_pre_wait1"}, {31'd0, bus1.wait_n}, 32'd1);
        if (iack) begin
            chk({tag, "_iack_hit0"}, {31'd0, hit0}, 32'd0);
            chk({tag, "_iack_hit1"}, {31'd0, hit1}, 32'd0);
        end
        first0 = 1; first1 = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (!bus0.wait_n) lows0++;
            if (!bus1.wait_n) lows1++;
            if (k == 0) begin first0 = bus0.wait_n; first1 = bus1.wait_n; end
        end
        chk({tag, "_lows0"}, lows0, 32'd1);
        chk({tag, "_lows1"}, lows1, 32'd2);
        chk({tag, "_first0"}, first0, 32'd0);
        chk({tag, "_first1"}, first1, 32'd0);
        @(posedge clk); #1;
        idle_bus();
        bus0.mreq_n = 1'b0; bus0.rfsh_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (!bus0.wait_n || !bus1.wait_n) rf_lows++;
        end
        chk({tag, "_rfsh_lows"}, rf_lows, 32'd0);
        @(posedge clk); #1;
        idle_bus();
    endtask

    logic [7:0] ports [7];
    logic [7:0] p, d;
    int         lows;

    initial begin
        ports[0] = 8'hA8; ports[1] = 8'hFC; ports[2] = 8'hFD; ports[3] = 8'hFE;
        ports[4] = 8'hFF; ports[5] = 8'h10; ports[6] = 8'h00;
        idle_bus();
        bus0.A = 16'h0000; bus0.cpu_dout = 8'h00;
        reset_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wait0", {31'd0, bus0.wait_n}, 32'd1);
        chk("rst_wait1", {31'd0, bus1.wait_n}, 32'd1);
        chk("rst_slot0", {24'd0, slot0}, 32'h00);
        chk("rst_slot1", {24'd0, slot1}, 32'h00);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 1; i < 5; i++) chk_io(ports[i]);
        chk_map(16'h0000);
        chk_map(16'hC123);

        // M1 waits, refresh and plain memory reads
        m1_cycle("fetch", 16'h0100, 1'b0);
        @(posedge clk); #1;
        bus0.A = 16'h2345; bus0.mreq_n = 1'b0; bus0.rd_n = 1'b0;
        lows = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (!bus0.wait_n || !bus1.wait_n) lows++;
        end
        chk("memrd_lows", lows, 32'd0);
        @(posedge clk); #1;
        idle_bus();

        // Slot register and page decode
        io_write(8'hA8, 8'hE4);
        chk("slot0_e4", {24'd0, slot0}, {24'd0, m_slot});
        chk("slot1_e4", {24'd0, slot1}, {24'd0, m_slot});
        chk_map(16'h0000);
        chk_map(16'h4000);
        chk_map(16'h8000);
        chk_map(16'hC000);

        // Mapper write, then back-to-back writes to one register
        io_write(8'hFE, 8'h05);
        chk_map(16'h9234);
        io_write(8'hFF, 8'h0A);
        io_write(8'hFF, 8'h0B);
        chk_map(16'hF00F);
        chk_io(8'hFF);

        // I/O reads: owned, foreign, mapper
        chk_io(8'hA8);
        chk_io(8'h10);
        chk_io(8'hFC);

        // Interrupt acknowledge addressed like A8h
        m1_cycle("iack", 16'h00A8, 1'b1);
        chk("iack_slot0", {24'd0, slot0}, {24'd0, m_slot});
        chk("iack_slot1", {24'd0, slot1}, {24'd0, m_slot});

        // Random traffic
        for (int it = 0; it < 60; it++) begin
            p = ports[$urandom_range(0, 6)];
            if (p == 8'h00) p = 8'($urandom);
            d = 8'($urandom);
            case ($urandom_range(0, 2))
                0: io_write(p, d);
                1: chk_io(p);
                default: chk_map(16'($urandom));
            endcase
        end
        chk("rand_slot0", {24'd0, slot0}, {24'd0, m_slot});

        // Asynchronous reset during the wait window
        io_write(8'hA8, 8'h39);
        @(posedge clk); #1;
        bus0.A = 16'h0200; bus0.m1_n = 1'b0; bus0.mreq_n = 1'b0; bus0.rd_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("prerst_wait1", {31'd0, bus1.wait_n}, 32'd0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_wait0", {31'd0, bus0.wait_n}, 32'd1);
        chk("midrst_wait1", {31'd0, bus1.wait_n}, 32'd1);
        chk("midrst_slot0", {24'd0, slot0}, 32'h00);
        chk("midrst_slot1", {24'd0, slot1}, 32'h00);
        idle_bus();
        model_reset();
        for (int i = 1; i < 5; i++) chk_io(ports[i]);
        @(negedge clk);
        reset_n = 1'b1;
        m1_cycle("post_rst", 16'h0000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
